usb_tx_encoder: RTL and testbench
=================================

// Module: usb_tx_encoder
// PURPOSE
//  Full-speed USB transmit serializer; transmit-side counterpart of the receive timer/decoder path.
//  Pulls bytes from the TX buffer, sends SYNC, then payload LSB-first, bit-stuffed and NRZI-coded.
//  Closes each packet with EOP. Drives the D+/D- output pair for the bus driver.
//  Bit period is a fixed number of clk cycles (8 clk per bit at the 12 Mb/s full-speed rate).
// PARAMETERS
//  CLKS_PER_BIT   8      clk cycles per bus bit; must be >= 2
//  SYNC_BYTE      8'h80  sync pattern; sent LSB-first
// PORTS
//  clk            in   1  system clock, rising edge
//  n_rst          in   1  asynchronous, active-low reset
//  tx_start       in   1  1-cycle request to begin a packet; ignored unless tx_active=0
//  tx_byte        in   8  next payload byte
//  byte_valid     in   1  tx_byte/byte_last hold valid data
//  byte_last      in   1  tx_byte is the final payload byte
//  byte_ack       out  1  1-cycle pulse: tx_byte was consumed
//  dplus_out      out  1  D+ line, registered
//  dminus_out     out  1  D- line, registered
//  tx_active      out  1  high while a packet is on the bus
//  tx_done        out  1  1-cycle pulse: packet finished normally
//  tx_error       out  1  1-cycle pulse: underrun abort
// BEHAVIOUR
//  Reset (async): state IDLE; dplus_out=1, dminus_out=0 (J); all other outputs 0; ones count 0.
//  Line states: J=(1,0), K=(0,1), SE0=(0,0). The IDLE bus state is J.
//  NRZI: a 0 bit toggles J<->K. A 1 bit holds the line. NRZI state restarts from J each packet.
//  Bit timer: a mod-CLKS_PER_BIT counter, restarted on tx_start. Each bus bit lasts exactly CLKS_PER_BIT clks.
//  FSM: IDLE -> SYNC -> DATA -> EOP_SE0 -> EOP_J -> IDLE.
//  IDLE: if tx_start=1 at edge k, SYNC bit0 appears on the lines from edge k+1, and tx_active=1 from k+1.
//  SYNC: 8 bits of SYNC_BYTE. The SYNC bits count toward bit stuffing.
//  Byte load edge: the edge that begins the first bit after SYNC or after a byte's bit7.
//   If a stuff bit is due at that edge, the load is deferred to the end of the stuff bit.
//  At the load edge, with byte_valid=1:
//   - tx_byte and byte_last are latched; later changes do not affect the current byte.
//   - byte_ack=1 for the following cycle.
//   - bit0 drives the lines from that edge.
//  At the load edge, with byte_valid=0 (underrun):
//   - no byte_ack; tx_error pulses.
//   - EOP_SE0 begins at that edge; the packet is then closed normally, but tx_done is not pulsed.
//  Bit stuffing: the ones counter increments on each transmitted 1 and clears on each 0.
//   After six consecutive 1s, insert one 0 bit (a line toggle); the counter then clears.
//   A stuff bit due after the final data bit is sent before EOP.
//  Byte sequencing: after bit7 (and any pending stuff bit), byte_last=1 -> EOP_SE0; else -> next load.
//  EOP_SE0 lasts 2 bit times. EOP_J drives J for 1 bit time.
//  At the end of EOP_J: tx_active=0 and the FSM returns to IDLE.
//   tx_done pulses in that same cycle, unless the packet was aborted.
//  Packet length, N bytes, S stuff bits: (8 + 8N + S + 3) * CLKS_PER_BIT clks.
//  tx_start while tx_active=1: ignored, no queuing.
//  Reset mid-packet: lines return to J immediately; the partial packet is dropped; no done/error pulse.
//  byte_ack, tx_done and tx_error are never asserted in the same cycle.
// TESTING
//  1. Assert n_rst=0 mid-clock, no clk.
//     -> dplus=1, dminus=0; tx_active=0; byte_ack=0; tx_done=0; tx_error=0.
//  2. tx_start with 0x00 valid, byte_last=1.
//     -> lines K,J,K,J,K,J,K,K (SYNC), then J,K,J,K,J,K,J,K, each 8 clks.
//     -> SE0 for 16 clks, J for 8 clks; tx_done pulses at clk 152 after start.
//     -> byte_ack pulses once, at clk 65.
//  3. Single byte 0xFF, last.
//     -> stuff 0 inserted after the 5th data bit (SYNC supplies the 1st one).
//     -> line toggles there; tx_done pulses at clk 160.
//  4. Bytes 0xA5 then 0x3C (last), byte_valid held high.
//     -> byte_ack pulses exactly 64 clks apart; no stuff bits; decoded stream matches.
//     -> tx_done pulses at clk 216.
//  5. Byte 0x12 with byte_last=0, then byte_valid=0.
//     -> tx_error pulses at the second load edge; SE0 starts that edge; J follows; no tx_done.
//  6. Drop n_rst during DATA bit3.
//     -> lines go to J asynchronously; after release, a new tx_start sends a clean SYNC.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmit serializer: SYNC, then LSB-first bit-stuffed NRZI payload, then EOP.
// Every bus bit is decided on the clk edge that ends the previous bit; the line outputs are registered.
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ack,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned     CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_J_END = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bits_q;
  logic [7:0]    shift_q;
  logic          last_q;
  logic [2:0]    ones_q;
  logic          abort_q;
  logic          lvl_q;
  logic          dp_q;
  logic          dm_q;
  logic          ack_q;
  logic          done_q;
  logic          err_q;
  logic          active_q;

  logic          bit_end_s;
  logic          stuff_due_s;
  logic          byte_done_s;
  logic          send_bit_s;
  logic          send_lvl_d;
  logic [2:0]    ones_d;

  // NRZI: a 0 toggles the line level (1 = J), a 1 holds it.
  function automatic logic nrzi_level(input logic level, input logic bit_val);
    return bit_val ? level : ~level;
  endfunction

  // Selects the next bus bit: a pending stuff bit, the next bit of the current byte, or bit0 of a new byte.
  always_comb begin
    bit_end_s   = (cnt_q == CNT_LAST);
    stuff_due_s = (ones_q == 3'd6);
    byte_done_s = (bits_q == 4'd8);
    if (stuff_due_s) begin
      send_bit_s = 1'b0;
    end else if (!byte_done_s) begin
      send_bit_s = shift_q[bits_q[2:0]];
    end else begin
      send_bit_s = tx_byte[0];
    end
    send_lvl_d = nrzi_level(lvl_q, send_bit_s);
    ones_d     = send_bit_s ? (ones_q + 3'd1) : 3'd0;
  end

  // Packet sequencer: bit timer, stuffing, byte loading, EOP and the registered line/status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      bits_q   <= 4'd0;
      shift_q  <= 8'h00;
      last_q   <= 1'b0;
      ones_q   <= 3'd0;
      abort_q  <= 1'b0;
      lvl_q    <= 1'b1;
      dp_q     <= 1'b1;
      dm_q     <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= bit_end_s ? {CW{1'b0}} : (cnt_q + 1'b1);
      case (state_q)
        IDLE: begin
          // Parking the timer on its last count makes the next edge start SYNC bit0.
          cnt_q <= CNT_LAST;
          if (tx_start) begin
            state_q <= SYNC;
            shift_q <= SYNC_BYTE;
            bits_q  <= 4'd0;
            abort_q <= 1'b0;
          end
        end
        SYNC, DATA: begin
          active_q <= 1'b1;
          if (bit_end_s) begin
            if (stuff_due_s || !byte_done_s) begin
              lvl_q  <= send_lvl_d;
              dp_q   <= send_lvl_d;
              dm_q   <= ~send_lvl_d;
              ones_q <= ones_d;
              if (!stuff_due_s) begin
                bits_q <= bits_q + 4'd1;
              end
            end else if ((state_q == DATA) && last_q) begin
              state_q <= EOP_SE0;
              dp_q    <= 1'b0;
              dm_q    <= 1'b0;
              bits_q  <= 4'd0;
            end else if (byte_valid) begin
              state_q <= DATA;
              shift_q <= tx_byte;
              last_q  <= byte_last;
              ack_q   <= 1'b1;
              bits_q  <= 4'd1;
              lvl_q   <= send_lvl_d;
              dp_q    <= send_lvl_d;
              dm_q    <= ~send_lvl_d;
              ones_q  <= ones_d;
            end else begin
              err_q   <= 1'b1;
              abort_q <= 1'b1;
              state_q <= EOP_SE0;
              dp_q    <= 1'b0;
              dm_q    <= 1'b0;
              bits_q  <= 4'd0;
            end
          end
        end
        EOP_SE0: begin
          if (bit_end_s) begin
            if (bits_q == 4'd0) begin
              bits_q <= 4'd1;
            end else begin
              state_q <= EOP_J;
              lvl_q   <= 1'b1;
              dp_q    <= 1'b1;
              dm_q    <= 1'b0;
            end
          end
        end
        EOP_J: begin
          // Leave one clk early: the idle J completes this bit, so a new start keeps exact spacing.
          if (cnt_q == CNT_J_END) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            done_q   <= ~abort_q;
            ones_q   <= 3'd0;
          end
        end
        default: begin
          state_q  <= IDLE;
          lvl_q    <= 1'b1;
          dp_q     <= 1'b1;
          dm_q     <= 1'b0;
          ones_q   <= 3'd0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ack   = ack_q;
  assign dplus_out  = dp_q;
  assign dminus_out = dm_q;
  assign tx_active  = active_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: hand-written expected line sequences (J/K/0 per bus bit)
// plus pulse positions, checked on every clk of each packet.
module tb_usb_tx_encoder;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       n_rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_last = 1'b0;
  logic       byte_ack;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_active;
  logic       tx_done;
  logic       tx_error;

  int n_tests = 0;
  int n_fail  = 0;

  usb_tx_encoder #(.CLKS_PER_BIT(8), .SYNC_BYTE(8'h80)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ack   (byte_ack),
    .dplus_out  (dplus_out),
    .dminus_out (dminus_out),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " lines"}, {6'd0, dplus_out, dminus_out}, 8'h02);
    chk({tag, " active"}, {7'd0, tx_active}, 8'h00);
    chk({tag, " ack"}, {7'd0, byte_ack}, 8'h00);
    chk({tag, " done"}, {7'd0, tx_done}, 8'h00);
    chk({tag, " error"}, {7'd0, tx_error}, 8'h00);
  endtask

  // r = clk edges since the edge that sampled tx_start; lines holds one J/K/0 per bus bit.
  task automatic run_packet(input string tag, input string lines, input int ack0, input int ack1,
                            input int err_at, input bit exp_done, input int chg_at,
                            input logic [7:0] chg_byte, input logic chg_valid, input logic chg_last,
                            input int start_at, input int stop_at);
    int         nclk;
    byte        c;
    logic [1:0] exp_ln;
    nclk = 8 * lines.len();
    tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    for (int r = 0; r <= nclk + 1; r++) begin
      if (r > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (r == 0 || r > nclk) c = "J";
      else c = lines[(r - 1) / 8];
      exp_ln = (c == "J") ? 2'b10 : ((c == "K") ? 2'b01 : 2'b00);
      chk($sformatf("%s lines r=%0d", tag, r), {6'd0, dplus_out, dminus_out}, {6'd0, exp_ln});
      chk($sformatf("%s ack r=%0d", tag, r), {7'd0, byte_ack}, {7'd0, (r == ack0) || (r == ack1)});
      chk($sformatf("%s error r=%0d", tag, r), {7'd0, tx_error}, {7'd0, r == err_at});
      chk($sformatf("%s done r=%0d", tag, r), {7'd0, tx_done}, {7'd0, exp_done && (r == nclk)});
      chk($sformatf("%s active r=%0d", tag, r), {7'd0, tx_active}, {7'd0, (r >= 1) && (r < nclk)});
      if (r == stop_at) break;
      if (r == chg_at) begin
        tx_byte    = chg_byte;
        byte_valid = chg_valid;
        byte_last  = chg_last;
      end
      tx_start = (r == start_at);
    end
    tx_start = 1'b0;
  endtask

  initial begin
    // Test 1: asynchronous reset with no clock running.
    #3 n_rst = 1'b0;
    #1 chk_idle("t1 reset");
    #6 n_rst = 1'b1;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("t1 idle");

    // Test 2: single 0x00, last.
    tx_byte = 8'h00; byte_valid = 1'b1; byte_last = 1'b1;
    run_packet("t2", "KJKJKJKKJKJKJKJK00J", 65, -1, -1, 1'b1, -1, 8'h00, 1'b1, 1'b1, -1, -1);

    // Test 3: single 0xFF, last; stuff bit after the 5th data bit.
    tx_byte = 8'hFF; byte_valid = 1'b1; byte_last = 1'b1;
    run_packet("t3", "KJKJKJKKKKKKKJJJJ00J", 65, -1, -1, 1'b1, -1, 8'h00, 1'b1, 1'b1, -1, -1);

    // Test 4: 0xA5 then 0x3C (last); tx_byte changes right after the first ack; stray tx_start mid-packet.
    tx_byte = 8'hA5; byte_valid = 1'b1; byte_last = 1'b0;
    run_packet("t4", "KJKJKJKKKJJKJJKKJKKKKKJK00J", 65, 129, -1, 1'b1, 65, 8'h3C, 1'b1, 1'b1, 20, -1);

    // Test 5: 0x12 not last, then underrun at the second load edge.
    tx_byte = 8'h12; byte_valid = 1'b1; byte_last = 1'b0;
    run_packet("t5", "KJKJKJKKJJKJJKJK00J", 65, -1, 129, 1'b0, 65, 8'hFF, 1'b0, 1'b0, -1, -1);

    // Test 6: reset during DATA bit3 (line is K there), then a clean packet.
    tx_byte = 8'h00; byte_valid = 1'b1; byte_last = 1'b1;
    run_packet("t6a", "KJKJKJKKJKJKJKJK00J", 65, -1, -1, 1'b1, -1, 8'h00, 1'b1, 1'b1, -1, 92);
    #2 n_rst = 1'b0;
    #1 chk_idle("t6 async");
    repeat (2) @(negedge clk);
    chk_idle("t6 held");
    n_rst = 1'b1;
    @(negedge clk);
    chk_idle("t6 released");
    run_packet("t6b", "KJKJKJKKJKJKJKJK00J", 65, -1, -1, 1'b1, -1, 8'h00, 1'b1, 1'b1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
